// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM state encoding,
// the "no key" code for consumers and the key-code width helper.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SCAN     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t HELD     = 2'd2;

  // Consumers slice this to their key-code width to mean "no key".
  localparam logic [31:0] KEY_NONE = '1;

  function automatic int key_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// One-hot column ring: holds each column for DWELL cycles, flags the last
// dwell cycle, stops while frozen and steps once on an advance pulse.
module keypad_col_driver #(
  parameter int NUM_COLS = 4,
  parameter int DWELL    = 4,
  localparam int CW      = $clog2(NUM_COLS),
  localparam int DW      = $clog2(DWELL)
) (
  input  logic                clk_out,
  input  logic                reset,
  input  logic                freeze,
  input  logic                advance,
  output logic [NUM_COLS-1:0] col_drive,
  output logic [CW-1:0]       col_idx,
  output logic                last_dwell
);

  logic [DW-1:0] dwell_cnt;

  // Independent of freeze so the capture decision can feed freeze without a loop.
  assign last_dwell = (dwell_cnt == DW'(DWELL - 1));

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      col_drive <= NUM_COLS'(1);
      col_idx   <= '0;
      dwell_cnt <= '0;
    end else if (advance || (!freeze && last_dwell)) begin
      col_drive <= {col_drive[NUM_COLS-2:0], col_drive[NUM_COLS-1]};
      col_idx   <= (col_idx == CW'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
      dwell_cnt <= '0;
    end else if (!freeze) begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobe, 2-flop row sync, debounce, ghost
// rejection and a valid/ready key event. Typematic repeat: KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_COLS      = 4,
  parameter int NUM_ROWS      = 3,
  parameter int DWELL         = 4,
  parameter int DEBOUNCE_CNT  = 8,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16,
  localparam int KEY_W        = key_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                clk_out,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_drive,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_pressed,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic [1:0]          fsm_state
);

  localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW  = $clog2(NUM_COLS);
  localparam int DBW = $clog2(DEBOUNCE_CNT + 1);

  // Handshake: an event is offered while key_valid=1 and is consumed on any
  // cycle with key_valid && key_ready; key_code never changes while offered.

  state_t              state;
  logic [NUM_ROWS-1:0] row_sync1, row_sync;
  logic [NUM_ROWS-1:0] row_hot;
  logic [RW-1:0]       row_idx, row_q;
  logic [CW-1:0]       col_idx, col_q;
  logic [DBW-1:0]      deb_cnt;
  logic [KEY_W-1:0]    event_code;
  logic last_dwell, hold, advance, capture, match, row_low, deb_last;
  logic press_fire, release_done, event_fire;

  assign fsm_state = state;

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      row_sync1 <= '0;
      row_sync  <= '0;
    end else begin
      row_sync1 <= row_in;
      row_sync  <= row_sync1;
    end
  end

  always_comb begin
    row_idx = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (row_sync[i]) row_idx = RW'(i);
  end

  assign match        = (row_sync == row_hot);
  assign row_low      = ((row_sync & row_hot) == '0);
  assign deb_last     = (deb_cnt == DBW'(DEBOUNCE_CNT - 1));
  assign capture      = (state == SCAN) && last_dwell && $onehot(row_sync);
  assign press_fire   = (state == DEBOUNCE) && match && deb_last;
  assign release_done = (state == HELD) && row_low && deb_last;
  assign advance      = ((state == DEBOUNCE) && !match) || release_done;
  assign hold         = (state != SCAN) || capture;
  assign event_code   = KEY_W'(int'(row_q) * NUM_COLS + int'(col_q));

  keypad_col_driver #(
    .NUM_COLS (NUM_COLS),
    .DWELL    (DWELL)
  ) u_col_driver (
    .clk_out    (clk_out),
    .reset      (reset),
    .freeze     (hold),
    .advance    (advance),
    .col_drive  (col_drive),
    .col_idx    (col_idx),
    .last_dwell (last_dwell)
  );

  // deb_cnt counts matching samples in DEBOUNCE and released samples in HELD.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      row_hot     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      deb_cnt     <= '0;
      key_pressed <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (capture) begin
            state   <= DEBOUNCE;
            row_hot <= row_sync;
            row_q   <= row_idx;
            col_q   <= col_idx;
            deb_cnt <= '0;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= SCAN;
          end else if (deb_last) begin
            state       <= HELD;
            key_pressed <= 1'b1;
            deb_cnt     <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!row_low) begin
            deb_cnt <= '0;
          end else if (deb_last) begin
            state       <= SCAN;
            key_pressed <= 1'b0;
            deb_cnt     <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW  = $clog2(RMAX + 1);

  logic [RPW-1:0] rep_cnt;
  logic           rep_armed;
  logic           rep_fire;

  // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
  assign rep_fire = (state == HELD) &&
                    (rep_armed ? (rep_cnt == RPW'(REPEAT_PERIOD - 1))
                               : (rep_cnt == RPW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (state != HELD) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign event_fire = press_fire || rep_fire;
`else
  assign event_fire = press_fire;
`endif

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (event_fire && (!key_valid || key_ready)) begin
        key_code  <= event_code;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear leaves overrun set.
      if (event_fire && key_valid && !key_ready)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (defaults 4 columns x 3 rows); the
// repeat scenario is included when KEYPAD_REPEAT_EN is defined.
module tb_keypad_scanner;

  logic       clk_out;
  logic       reset;
  logic [2:0] row_in;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_pressed;
  logic       overrun;
  logic       overrun_clr;
  logic [1:0] fsm_state;

  logic [11:0] keys;
  logic        force_low;
  logic [3:0]  exp_q[$];
  int          errors;
  int          checks;

  keypad_scanner dut (
    .clk_out     (clk_out),
    .reset       (reset),
    .row_in      (row_in),
    .col_drive   (col_drive),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_pressed (key_pressed),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .fsm_state   (fsm_state)
  );

  // clock / reset block
  initial begin
    clk_out = 1'b0;
    forever #5 clk_out = ~clk_out;
  end

  // Keypad matrix model: key r*4+c connects column c to row r.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col_drive[c]) row_in[r] = 1'b1;
    if (force_low) row_in = '0;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_out);
      #1;
    end
  endtask

  // Holds reset for two edges with the given keys down, then releases it
  // between edges so the next rising edge is the first scan edge.
  task automatic start(input logic [11:0] k);
    reset = 1'b0;
    keys  = k;
    step(2);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_pressed(input logic lvl, input int budget);
    int n;
    n = 0;
    while (key_pressed !== lvl && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    keys  = '0;
    step(1);
    checks++; if (col_drive !== 4'b0001) begin errors++; $display("FAIL reset_col_drive got=%b exp=0001", col_drive); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code got=%0d exp=0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%b exp=0", key_valid); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_key_pressed got=%b exp=0", key_pressed); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
  endtask

  // Key r1/c2 (code 6) down from reset: captured on the last dwell of column 2
  // (edge 12), key_valid rises at edge 20.
  task automatic test_press();
    key_ready = 1'b0;
    start(12'h1 << 6);
    step(4);
    checks++; if (col_drive !== 4'b0010) begin errors++; $display("FAIL press_rotate got=%b exp=0010", col_drive); end
    step(8);
    checks++; if (col_drive !== 4'b0100 || fsm_state !== 2'd1) begin errors++; $display("FAIL press_capture col=%b state=%0d exp col=0100 state=1", col_drive, fsm_state); end
    step(7);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_early_valid got=%b exp=0", key_valid); end
    step(1);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL press_event valid=%b code=%0d exp valid=1 code=6", key_valid, key_code); end
    checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL press_level got=%b exp=1", key_pressed); end
    key_ready = 1'b1;
    step(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_accept got=%b exp=0", key_valid); end
    step(10);
    checks++; if (key_valid !== 1'b0 || col_drive !== 4'b0100) begin errors++; $display("FAIL press_single valid=%b col=%b exp valid=0 col=0100", key_valid, col_drive); end
    keys = '0;
    step(9);
    checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL release_early got=%b exp=1", key_pressed); end
    step(1);
    checks++; if (key_pressed !== 1'b0 || col_drive !== 4'b1000) begin errors++; $display("FAIL release_done pressed=%b col=%b exp pressed=0 col=1000", key_pressed, col_drive); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL release_no_event got=%b exp=0", key_valid); end
  endtask

  // Row drops after edge 15; edge 18 sees the low sample at debounce count 5.
  task automatic test_bounce();
    key_ready = 1'b0;
    force_low = 1'b0;
    start(12'h1 << 6);
    step(15);
    force_low = 1'b1;
    step(3);
    force_low = 1'b0;
    checks++; if (col_drive !== 4'b1000 || fsm_state !== 2'd0) begin errors++; $display("FAIL bounce_abort col=%b state=%0d exp col=1000 state=0", col_drive, fsm_state); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_no_event got=%b exp=0", key_valid); end
    step(23);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL repress_early got=%b exp=0", key_valid); end
    step(1);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL repress_event valid=%b code=%0d exp valid=1 code=6", key_valid, key_code); end
  endtask

  // Keys r0/c0 and r1/c0 together give rows 011 on column 0.
  task automatic test_ghost();
    key_ready = 1'b0;
    start(12'h011);
    step(4);
    checks++; if (col_drive !== 4'b0010 || fsm_state !== 2'd0) begin errors++; $display("FAIL ghost_skip col=%b state=%0d exp col=0010 state=0", col_drive, fsm_state); end
    step(36);
    checks++; if (key_valid !== 1'b0 || key_pressed !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL ghost_idle valid=%b pressed=%b state=%0d exp 0 0 0", key_valid, key_pressed, fsm_state); end
  endtask

  task automatic test_overrun();
    key_ready   = 1'b0;
    overrun_clr = 1'b0;
    start(12'h1 << 1);
    wait_valid(100);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd1) begin errors++; $display("FAIL ovr_first valid=%b code=%0d exp valid=1 code=1", key_valid, key_code); end
    keys = '0;
    wait_pressed(1'b0, 100);
    keys = 12'h1 << 11;
    wait_pressed(1'b1, 100);
    checks++; if (key_pressed !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_set pressed=%b overrun=%b exp 1 1", key_pressed, overrun); end
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd1) begin errors++; $display("FAIL ovr_keep valid=%b code=%0d exp valid=1 code=1", key_valid, key_code); end
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    key_ready = 1'b1;
    step(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", key_valid); end
    keys = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [4];
    logic [3:0] exp;
    codes[0] = 4'd5; codes[1] = 4'd9; codes[2] = 4'd2; codes[3] = 4'd8;
    key_ready = 1'b1;
    start('0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(codes[i]);
      keys = 12'h1 << codes[i];
      wait_valid(100);
      exp = exp_q.pop_front();
      checks++; if (key_valid !== 1'b1 || key_code !== exp) begin errors++; $display("FAIL b2b_code[%0d] valid=%b code=%0d exp=%0d", i, key_valid, key_code, exp); end
      step(1);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b_deassert[%0d] got=%b exp=0", i, key_valid); end
      keys = '0;
      wait_pressed(1'b0, 100);
    end
    checks++; if (overrun !== 1'b0 || key_pressed !== 1'b0) begin errors++; $display("FAIL b2b_end overrun=%b pressed=%b exp 0 0", overrun, key_pressed); end
  endtask

  task automatic test_reset_mid_hold();
    key_ready = 1'b0;
    start(12'h1 << 7);
    wait_pressed(1'b1, 100);
    checks++; if (key_pressed !== 1'b1 || key_valid !== 1'b1) begin errors++; $display("FAIL midhold_setup pressed=%b valid=%b exp 1 1", key_pressed, key_valid); end
    reset = 1'b0;
    #1;
    checks++; if (col_drive !== 4'b0001 || key_code !== 4'd0) begin errors++; $display("FAIL midhold_reset col=%b code=%0d exp col=0001 code=0", col_drive, key_code); end
    checks++; if (key_valid !== 1'b0 || key_pressed !== 1'b0 || overrun !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL midhold_flags valid=%b pressed=%b overrun=%b state=%0d exp 0 0 0 0", key_valid, key_pressed, overrun, fsm_state); end
    keys = '0;
    step(1);
    reset = 1'b1;
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int events;
    key_ready = 1'b1;
    start(12'h1 << 6);
    wait_valid(100);
    events = (key_valid === 1'b1 && key_code === 4'd6) ? 1 : 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (key_valid === 1'b1 && key_code === 4'd6) events++;
    end
    checks++; if (events !== 5) begin errors++; $display("FAIL repeat_count got=%0d exp=5", events); end
    checks++; if (overrun !== 1'b0 || key_pressed !== 1'b1) begin errors++; $display("FAIL repeat_state overrun=%b pressed=%b exp 0 1", overrun, key_pressed); end
    reset = 1'b0;
    #1;
    checks++; if (col_drive !== 4'b0001 || key_valid !== 1'b0 || key_pressed !== 1'b0 || key_code !== 4'd0) begin errors++; $display("FAIL repeat_reset col=%b valid=%b pressed=%b code=%0d exp 0001 0 0 0", col_drive, key_valid, key_pressed, key_code); end
    keys = '0;
    step(1);
    reset = 1'b1;
  endtask
`endif

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b0;
    keys        = '0;
    force_low   = 1'b0;
    key_ready   = 1'b0;
    overrun_clr = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_ghost();
    test_overrun();
    test_back_to_back();
    test_reset_mid_hold();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
